// File: rtl/cluster_link_pkg.sv
// Shared widths, constants and FSM encoding for the cluster link framer.
// ZERO_SUPPRESS_EN (see cluster_link_framer) does not change anything here.
package cluster_link_pkg;

  localparam int MXCLSTBITS = 14;
  localparam int MXADRBITS  = 11;
  localparam int MXPADS     = 1536;
  localparam int MXOUTBITS  = 56;
  localparam int NCLST      = 8;

  localparam logic [11:0] BX_MAX     = 12'd3563;
  localparam logic [7:0]  HDR_MARKER = 8'hBC;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    FRM_A,
    FRM_B
  } state_e;

  function automatic logic adr_valid(
    input logic [MXADRBITS-1:0] adr
  );
    return adr < MXADRBITS'(MXPADS);
  endfunction

endpackage

// File: rtl/cluster_valid_count.sv
// Counts clusters whose address is a real pad and flags
// which half (0-3, 4-7) holds at least one of them.
module cluster_valid_count
  import cluster_link_pkg::*;
(
  input  logic [NCLST*MXCLSTBITS-1:0] clusters_i,
  output logic [3:0]                  count_o,
  output logic                        grp_lo_o,
  output logic                        grp_hi_o
);

  logic [NCLST-1:0]   vld;
  logic [NCLST*3-1:0] unused_cnt_bits;

  always_comb begin
    vld             = '0;
    count_o         = '0;
    unused_cnt_bits = '0;
    for (int i = 0; i < NCLST; i++) begin
      vld[i] = adr_valid(
        clusters_i[i*MXCLSTBITS +: MXADRBITS]);
      count_o = count_o + 4'(vld[i]);
      unused_cnt_bits[i*3 +: 3] =
        clusters_i[i*MXCLSTBITS+MXADRBITS +: 3];
    end
  end

  assign grp_lo_o = |vld[3:0];
  assign grp_hi_o = |vld[7:4];

endmodule

// File: rtl/cluster_link_framer.sv
// Frames 8 packer clusters per bunch crossing into 56-bit link words.
// Define ZERO_SUPPRESS_EN to skip cluster words whose 4 slots are empty.
module cluster_link_framer
  import cluster_link_pkg::*;
(
  input  logic        clock4x,
  input  logic        global_reset_n,
  input  logic        bx_strobe,
  input  logic        bc0,
  input  logic [13:0] cluster0,
  input  logic [13:0] cluster1,
  input  logic [13:0] cluster2,
  input  logic [13:0] cluster3,
  input  logic [13:0] cluster4,
  input  logic [13:0] cluster5,
  input  logic [13:0] cluster6,
  input  logic [13:0] cluster7,
  output logic [55:0] link_data,
  output logic        link_valid,
  output logic        link_sof,
  output logic [7:0]  err_count
);

  localparam int CW = NCLST * MXCLSTBITS;

  state_e state_q, state_d;

  logic [CW-1:0]        clst_all, clst_q;
  logic [3:0]           cnt, cnt_q;
  logic                 grp_lo, grp_hi;
  logic                 bc0_q, coll_q, coll_d;
  logic [11:0]          bxn_q, bxn_d, bxn_cap_q;
  logic [7:0]           err_q, err_d;
  logic [MXOUTBITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 sof_q, sof_d;
  logic                 accept, drop;

  assign clst_all = {cluster7, cluster6, cluster5, cluster4,
                     cluster3, cluster2, cluster1, cluster0};

  cluster_valid_count u_cnt (
    .clusters_i (clst_all),
    .count_o    (cnt),
    .grp_lo_o   (grp_lo),
    .grp_hi_o   (grp_hi)
  );

`ifdef ZERO_SUPPRESS_EN
  logic grp_lo_q, grp_hi_q;
`else
  logic unused_grp;
  assign unused_grp = grp_lo ^ grp_hi;
`endif

  assign accept = bx_strobe &&
                  (state_q == IDLE || state_q == FRM_B);
  assign drop   = bx_strobe && !accept;

  always_comb begin
    bxn_d = bxn_q;
    if (bx_strobe) begin
      if (bc0 || bxn_q == BX_MAX) bxn_d = '0;
      else                        bxn_d = bxn_q + 12'd1;
    end
  end

  // A drop on the header edge must survive into the next header.
  assign coll_d = drop ? 1'b1 :
                  (state_q == HDR) ? 1'b0 : coll_q;

  assign err_d = (drop && err_q != 8'hFF) ?
                 err_q + 8'd1 : err_q;

  always_comb begin
    state_d = state_q;
    data_d  = '0;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = HDR;
      end
      HDR: begin
        data_d  = {HDR_MARKER, bxn_cap_q, cnt_q,
                   bc0_q, coll_q, 30'd0};
        valid_d = 1'b1;
        sof_d   = 1'b1;
`ifdef ZERO_SUPPRESS_EN
        if (grp_lo_q)      state_d = FRM_A;
        else if (grp_hi_q) state_d = FRM_B;
        else               state_d = IDLE;
`else
        state_d = FRM_A;
`endif
      end
      FRM_A: begin
        data_d  = clst_q[CW/2-1:0];
        valid_d = 1'b1;
`ifdef ZERO_SUPPRESS_EN
        state_d = grp_hi_q ? FRM_B : IDLE;
`else
        state_d = FRM_B;
`endif
      end
      FRM_B: begin
        data_d  = clst_q[CW-1:CW/2];
        valid_d = 1'b1;
        state_d = accept ? HDR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock4x) begin
    if (!global_reset_n) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  always_ff @(posedge clock4x) begin
    if (!global_reset_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      err_q     <= '0;
      bxn_q     <= '0;
      coll_q    <= 1'b0;
      clst_q    <= '0;
      cnt_q     <= '0;
      bc0_q     <= 1'b0;
      bxn_cap_q <= '0;
`ifdef ZERO_SUPPRESS_EN
      grp_lo_q  <= 1'b0;
      grp_hi_q  <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      err_q   <= err_d;
      bxn_q   <= bxn_d;
      coll_q  <= coll_d;
      if (accept) begin
        clst_q    <= clst_all;
        cnt_q     <= cnt;
        bc0_q     <= bc0;
        bxn_cap_q <= bxn_d;
`ifdef ZERO_SUPPRESS_EN
        grp_lo_q  <= grp_lo;
        grp_hi_q  <= grp_hi;
`endif
      end
    end
  end

  assign link_data  = data_q;
  assign link_valid = valid_q;
  assign link_sof   = sof_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_cluster_link_framer.sv
// Directed bench for cluster_link_framer with a word scoreboard.
// Follows ZERO_SUPPRESS_EN the same way the design does.
module tb_cluster_link_framer;

  logic        clk = 1'b0;
  logic        rst_n, stb, bc0;
  logic [13:0] c [0:7];
  logic [55:0] link_data;
  logic        link_valid, link_sof;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  cluster_link_framer dut (
    .clock4x        (clk),
    .global_reset_n (rst_n),
    .bx_strobe      (stb),
    .bc0            (bc0),
    .cluster0       (c[0]),
    .cluster1       (c[1]),
    .cluster2       (c[2]),
    .cluster3       (c[3]),
    .cluster4       (c[4]),
    .cluster5       (c[5]),
    .cluster6       (c[6]),
    .cluster7       (c[7]),
    .link_data      (link_data),
    .link_valid     (link_valid),
    .link_sof       (link_sof),
    .err_count      (err_count)
  );

  typedef struct {
    logic [55:0] d;
    logic        s;
  } exp_t;

  exp_t        sbq [$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [11:0] m_bxn  = '0;
  logic        m_coll = 1'b0;
  int          m_err  = 0;
  int          k_next = 100;
  int          need   = 3;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected behaviour of one strobe, derived from frame timing.
  task automatic model_strobe(input logic b0);
    logic [3:0] cnt;
    logic       g0, g1;
    exp_t       e;
    if (b0 || m_bxn == 12'd3563) m_bxn = '0;
    else                         m_bxn = m_bxn + 12'd1;
    if (k_next < need) begin
      m_coll = 1'b1;
      if (m_err < 255) m_err++;
      return;
    end
    cnt = '0;
    g0  = 1'b0;
    g1  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (c[i][10:0] < 11'd1536) begin
        cnt++;
        if (i < 4) g0 = 1'b1;
        else       g1 = 1'b1;
      end
    end
    e.d = {8'hBC, m_bxn, cnt, b0, m_coll, 30'd0};
    e.s = 1'b1;
    sbq.push_back(e);
    m_coll = 1'b0;
    e.s = 1'b0;
`ifdef ZERO_SUPPRESS_EN
    if (g0) begin
      e.d = {c[3], c[2], c[1], c[0]};
      sbq.push_back(e);
    end
    if (g1) begin
      e.d = {c[7], c[6], c[5], c[4]};
      sbq.push_back(e);
    end
    if (g1)      need = 1 + int'(g0) + 1;
    else if (g0) need = 3;
    else         need = 2;
`else
    e.d = {c[3], c[2], c[1], c[0]};
    sbq.push_back(e);
    e.d = {c[7], c[6], c[5], c[4]};
    sbq.push_back(e);
    need = 3;
    if (g0 ^ g1) need = 3;
`endif
    k_next = 0;
  endtask

  task automatic tick(input logic s, input logic b0);
    stb = s;
    bc0 = b0;
    if (!rst_n) begin
      m_bxn  = '0;
      m_coll = 1'b0;
      m_err  = 0;
      k_next = 100;
      sbq.delete();
    end else if (s) begin
      model_strobe(b0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    k_next++;
    stb = 1'b0;
    bc0 = 1'b0;
  endtask

  task automatic rand_clusters();
    for (int i = 0; i < 8; i++)
      c[i] = {3'($urandom_range(0, 7)),
              11'($urandom_range(0, 2047))};
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (link_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL extra_word observed=%h expected=none",
               link_data);
      end else begin
        e = sbq.pop_front();
        chk("word", link_data, e.d);
        chk("sof", link_sof, e.s);
      end
    end
  end

  logic [11:0] wrap_exp [0:3];
  logic        v_exp    [0:7];
  logic        s_exp    [0:7];

  initial begin
    wrap_exp = '{12'd3562, 12'd3563, 12'd0, 12'd1};
    v_exp    = '{0, 1, 1, 1, 1, 1, 1, 0};
    s_exp    = '{0, 1, 0, 0, 1, 0, 0, 0};
    rst_n = 1'b0;
    stb   = 1'b0;
    bc0   = 1'b0;
    for (int i = 0; i < 8; i++) c[i] = 14'h07FF;
    tick(0, 0);
    tick(0, 0);
    chk("rst_valid", link_valid, 0);
    chk("rst_sof", link_sof, 0);
    chk("rst_data", link_data, 0);
    chk("rst_err", err_count, 0);
    rst_n = 1'b1;
    tick(0, 0);

    c[0] = 14'h1005;
    tick(1, 1);
    tick(0, 0);
    chk("hdr0", link_data, 56'hBC000180000000);
    chk("hdr0_sof", link_sof, 1);
    tick(0, 0);
    chk("frmA0", link_data[13:0], 14'h1005);
    tick(0, 0);
    tick(0, 0);

    for (int i = 0; i < 3561; i++) begin
      rand_clusters();
      tick(1, 0);
      tick(0, 0);
      tick(0, 0);
      tick(0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      rand_clusters();
      tick(1, 0);
      tick(0, 0);
      chk("bxn_wrap", link_data[47:36], wrap_exp[i]);
      tick(0, 0);
      tick(0, 0);
    end

    rand_clusters();
    tick(1, 0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    chk("err_one", err_count, 1);
    tick(1, 0);
    tick(0, 0);
    chk("coll_set", link_data[30], 1);
    tick(0, 0);
    tick(0, 0);
    tick(1, 0);
    tick(0, 0);
    chk("coll_clr", link_data[30], 0);
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < 299; i++) begin
      rand_clusters();
      tick(1, 0);
      tick(1, 0);
      tick(0, 0);
      tick(0, 0);
    end
    chk("err_sat", err_count, 255);
    chk("err_model", err_count, m_err);

    for (int i = 0; i < 8; i++) c[i] = {3'd1, 11'(i * 100)};
    for (int j = 0; j < 8; j++) begin
      tick(j == 0 || j == 3, 0);
      chk("b2b_valid", link_valid, v_exp[j]);
      chk("b2b_sof", link_sof, s_exp[j]);
    end

    tick(1, 0);
    tick(0, 0);
    rst_n = 1'b0;
    tick(0, 0);
    chk("midrst_valid", link_valid, 0);
    chk("midrst_data", link_data, 0);
    chk("midrst_err", err_count, 0);
    tick(1, 0);
    chk("rststb_valid", link_valid, 0);
    rst_n = 1'b1;
    tick(1, 0);
    tick(0, 0);
    chk("postrst_bxn", link_data[47:36], 12'd1);
    chk("postrst_coll", link_data[30], 0);
    tick(0, 0);
    tick(0, 0);

    for (int i = 0; i < 8; i++) c[i] = 14'h07FF;
    c[0] = {3'd3, 11'd1535};
    c[1] = {3'd4, 11'd1536};
    tick(1, 0);
    tick(0, 0);
    chk("cnt_boundary", link_data[35:32], 4'd1);
    tick(0, 0);
    tick(0, 0);

`ifdef ZERO_SUPPRESS_EN
    for (int i = 0; i < 8; i++) c[i] = 14'h07FF;
    tick(1, 0);
    tick(0, 0);
    chk("zs_cnt0", link_data[35:32], 4'd0);
    tick(0, 0);
    chk("zs_hdr_only", link_valid, 0);
    tick(0, 0);
    tick(0, 0);
    c[5] = {3'd2, 11'd100};
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    chk("zs_frmB", link_data, {c[7], c[6], c[5], c[4]});
    tick(0, 0);
    chk("zs_end", link_valid, 0);
    tick(0, 0);
`else
    for (int i = 0; i < 6; i++) begin
      rand_clusters();
      tick(1, i[0]);
      tick(0, 0);
      tick(0, 0);
      tick(0, 0);
    end
`endif

    tick(0, 0);
    tick(0, 0);
    tick(0, 0);
    tick(0, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
